// File: rtl/config_pkg.sv
// Shared types for the register-file read path: opcode, read beat, operand
// bundle and the operand collector state encoding.
package config_pkg;

  localparam int DATA_W    = 32;
  localparam int CODE_W    = 8;
  localparam int NUM_BEATS = 4;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    code_t opcode;
    data_t op_a;
    data_t op_b;
    data_t op_c;
    data_t op_d;
  } opbundle_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } opcoll_state_e;

endpackage

// File: rtl/operand_collector.sv
// Operand collector: pairs one opcode with its four in-order register-file read
// beats and hands the bundle to execute. OPCOLL_STATS_EN adds bundle/stall counters.
module operand_collector #(
  parameter int DATA_W = config_pkg::DATA_W
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  config_pkg::code_t     opcode_i,
  input  logic                  opcode_valid_i,
  output logic                  opcode_ready_o,
  input  logic [DATA_W-1:0]     rd_data_i,
  input  logic                  rd_data_valid_i,
  output logic                  rd_data_ready_o,
  output config_pkg::opbundle_t bundle_o,
  output logic                  bundle_valid_o,
  input  logic                  bundle_ready_i
`ifdef OPCOLL_STATS_EN
 ,output logic [15:0]           bundle_cnt_o,
  output logic [15:0]           stall_cnt_o
`endif
);
  import config_pkg::*;

  // state   | meaning
  // IDLE    | waiting for an opcode; data is held off
  // COLLECT | taking beats in order into op_a..op_d
  // HOLD    | bundle valid and frozen until execute takes it

  localparam logic [1:0] LAST_BEAT = 2'(NUM_BEATS - 1);

  opcoll_state_e state_q, state_d;
  logic [1:0]    beat_cnt_q;
  opbundle_t     bundle_q;
  logic          load_op;
  logic          load_beat;
  data_t         beat;

  assign beat     = data_t'(rd_data_i);
  assign bundle_o = bundle_q;

  always_comb begin
    state_d         = state_q;
    opcode_ready_o  = 1'b0;
    rd_data_ready_o = 1'b0;
    bundle_valid_o  = 1'b0;
    load_op         = 1'b0;
    load_beat       = 1'b0;
    case (state_q)
      IDLE: begin
        opcode_ready_o = 1'b1;
        if (opcode_valid_i) begin
          load_op = 1'b1;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        rd_data_ready_o = 1'b1;
        if (rd_data_valid_i) begin
          load_beat = 1'b1;
          if (beat_cnt_q == LAST_BEAT) state_d = HOLD;
        end
      end
      HOLD: begin
        bundle_valid_o = 1'b1;
        // Next opcode may be taken in the same cycle the bundle leaves.
        opcode_ready_o = bundle_ready_i;
        if (bundle_ready_i) begin
          if (opcode_valid_i) begin
            load_op = 1'b1;
            state_d = COLLECT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      bundle_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_op) begin
        bundle_q.opcode <= opcode_i;
        beat_cnt_q      <= '0;
      end
      if (load_beat) begin
        case (beat_cnt_q)
          2'd0:    bundle_q.op_a <= beat;
          2'd1:    bundle_q.op_b <= beat;
          2'd2:    bundle_q.op_c <= beat;
          default: bundle_q.op_d <= beat;
        endcase
        beat_cnt_q <= beat_cnt_q + 2'd1;
      end
    end
  end

`ifdef OPCOLL_STATS_EN
  logic bundle_hs;
  logic stall;

  assign bundle_hs = (state_q == HOLD) && bundle_ready_i;
  assign stall     = ((state_q == COLLECT) && !rd_data_valid_i) ||
                     ((state_q == HOLD) && !bundle_ready_i);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      bundle_cnt_o <= '0;
      stall_cnt_o  <= '0;
    end else begin
      if (bundle_hs) bundle_cnt_o <= bundle_cnt_o + 16'd1;
      if (stall)     stall_cnt_o  <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_collector.sv
// Scoreboard bench for operand_collector: directed latency/backpressure/reset
// cases, then randomized independent opcode/data/ready streams.
module tb_operand_collector;
  import config_pkg::*;

  logic      clk_i = 1'b0;
  logic      srst_i;
  code_t     opcode_i;
  logic      opcode_valid_i;
  logic      opcode_ready_o;
  data_t     rd_data_i;
  logic      rd_data_valid_i;
  logic      rd_data_ready_o;
  opbundle_t bundle_o;
  logic      bundle_valid_o;
  logic      bundle_ready_i;
`ifdef OPCOLL_STATS_EN
  logic [15:0] bundle_cnt_o;
  logic [15:0] stall_cnt_o;
`endif

  operand_collector dut (
    .clk_i           (clk_i),
    .srst_i          (srst_i),
    .opcode_i        (opcode_i),
    .opcode_valid_i  (opcode_valid_i),
    .opcode_ready_o  (opcode_ready_o),
    .rd_data_i       (rd_data_i),
    .rd_data_valid_i (rd_data_valid_i),
    .rd_data_ready_o (rd_data_ready_o),
    .bundle_o        (bundle_o),
    .bundle_valid_o  (bundle_valid_o),
    .bundle_ready_i  (bundle_ready_i)
`ifdef OPCOLL_STATS_EN
   ,.bundle_cnt_o    (bundle_cnt_o),
    .stall_cnt_o     (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int        checks = 0;
  int        passes = 0;
  opbundle_t exp_q[$];
  bit        prev_stall = 1'b0;
  opbundle_t prev_bundle;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every bundle handshake must match the oldest expected bundle, and a
  // stalled bundle must stay valid and unchanged.
  always @(negedge clk_i) begin
    if (srst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", bundle_valid_o, 1);
        check("hold_stable", bundle_o, prev_bundle);
      end
      if (bundle_valid_o && bundle_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_bundle: got %0h expected none", bundle_o);
        end else begin
          check("bundle", bundle_o, exp_q.pop_front());
        end
      end
      prev_stall  = bundle_valid_o && !bundle_ready_i;
      prev_bundle = bundle_o;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Caller is just after a posedge with the DUT idle; returns at the negedge of
  // the first cycle the bundle should be valid.
  task automatic send_bundle(input code_t op, input data_t b0, b1, b2, b3, input int gap);
    data_t b[4];
    b = '{b0, b1, b2, b3};
    exp_q.push_back(opbundle_t'{op, b0, b1, b2, b3});
    opcode_i = op;
    opcode_valid_i = 1'b1;
    @(negedge clk_i);
    check("idle_opcode_ready", opcode_ready_o, 1);
    tick();
    opcode_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2 && gap > 0) begin
        rd_data_valid_i = 1'b0;
        repeat (gap) tick();
      end
      rd_data_i = b[i];
      rd_data_valid_i = 1'b1;
      if (i == 3) begin
        @(negedge clk_i);
        check("valid_not_early", bundle_valid_o, 0);
      end
      tick();
    end
    rd_data_valid_i = 1'b0;
    @(negedge clk_i);
    check("valid_on_time", bundle_valid_o, 1);
  endtask

  task automatic wait_hs(input bit is_op, output bit ok);
    int g = 0;
    @(negedge clk_i);
    while (!(is_op ? opcode_ready_o : rd_data_ready_o) && g < 2000) begin
      tick();
      @(negedge clk_i);
      g++;
    end
    ok = is_op ? opcode_ready_o : rd_data_ready_o;
    tick();
  endtask

  initial begin
    code_t ops[$];
    data_t dq[$];
    // Reset with every input asserted
    srst_i = 1'b1;
    opcode_i = 8'hF;
    opcode_valid_i = 1'b1;
    rd_data_i = 32'hEE;
    rd_data_valid_i = 1'b1;
    bundle_ready_i = 1'b1;
    tick();
    tick();
    srst_i = 1'b0;
    opcode_valid_i = 1'b0;
    rd_data_valid_i = 1'b0;
    @(negedge clk_i);
    check("rst_opcode_ready", opcode_ready_o, 1);
    check("rst_rd_ready", rd_data_ready_o, 0);
    check("rst_valid", bundle_valid_o, 0);
    check("rst_bundle", bundle_o, 0);
`ifdef OPCOLL_STATS_EN
    check("rst_bundle_cnt", bundle_cnt_o, 0);
    check("rst_stall_cnt", stall_cnt_o, 0);
`endif
    tick();

    // Single bundle, no stalls: valid at N+5 for exactly one cycle
    send_bundle(8'h5, 32'h11, 32'h22, 32'h33, 32'h44, 0);
    tick();
    @(negedge clk_i);
    check("valid_one_cycle", bundle_valid_o, 0);
    tick();

    // Three-cycle data gap between the second and third beats: valid at N+8
    send_bundle(8'h5, 32'h11, 32'h22, 32'h33, 32'h44, 3);
    tick();
    @(negedge clk_i);
    check("gap_valid_drop", bundle_valid_o, 0);
`ifdef OPCOLL_STATS_EN
    check("gap_bundle_cnt", bundle_cnt_o, 2);
    check("gap_stall_cnt", stall_cnt_o, 3);
`endif
    tick();

    // Output backpressure for four HOLD cycles, next opcode waiting
    bundle_ready_i = 1'b0;
    send_bundle(8'h9, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 0);
    tick();
    opcode_i = 8'h6;
    opcode_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("bp_valid", bundle_valid_o, 1);
      check("bp_bundle", bundle_o, opbundle_t'{8'h9, 32'hA1, 32'hA2, 32'hA3, 32'hA4});
      check("bp_opcode_ready", opcode_ready_o, 0);
      check("bp_rd_ready", rd_data_ready_o, 0);
      tick();
    end
    bundle_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_release_opcode_ready", opcode_ready_o, 1);
    exp_q.push_back(opbundle_t'{8'h6, 32'h61, 32'h62, 32'h63, 32'h64});
    tick();
    opcode_valid_i = 1'b0;
    rd_data_i = 32'h61;
    rd_data_valid_i = 1'b1;
    @(negedge clk_i);
    check("bp_collect_entered", rd_data_ready_o, 1);
    check("bp_collect_not_valid", bundle_valid_o, 0);
    tick();
    for (int i = 2; i <= 4; i++) begin
      rd_data_i = 32'h60 + 32'(i);
      tick();
    end
    rd_data_valid_i = 1'b0;
    @(negedge clk_i);
    check("bp_next_valid", bundle_valid_o, 1);
    tick();

    // Early data while idle is not taken; it becomes op_a once the opcode lands
    rd_data_i = 32'hAA;
    rd_data_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("early_rd_ready", rd_data_ready_o, 0);
      tick();
    end
    opcode_i = 8'h7;
    opcode_valid_i = 1'b1;
    @(negedge clk_i);
    check("simul_rd_ready", rd_data_ready_o, 0);
    check("simul_opcode_ready", opcode_ready_o, 1);
    exp_q.push_back(opbundle_t'{8'h7, 32'hAA, 32'hBB, 32'hCC, 32'hDD});
    tick();
    opcode_valid_i = 1'b0;
    tick();
    rd_data_i = 32'hBB;
    tick();
    rd_data_i = 32'hCC;
    tick();
    rd_data_i = 32'hDD;
    tick();
    rd_data_valid_i = 1'b0;
    @(negedge clk_i);
    check("early_valid", bundle_valid_o, 1);
`ifdef OPCOLL_STATS_EN
    check("early_stall_cnt", stall_cnt_o, 7);
`endif
    tick();

    // Reset after two of four beats discards the partial bundle
    opcode_i = 8'h8;
    opcode_valid_i = 1'b1;
    tick();
    opcode_valid_i = 1'b0;
    rd_data_i = 32'h81;
    rd_data_valid_i = 1'b1;
    tick();
    rd_data_i = 32'h82;
    tick();
    rd_data_valid_i = 1'b0;
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      check("mid_rst_no_valid", bundle_valid_o, 0);
      tick();
    end
    send_bundle(8'h3, 32'h31, 32'h32, 32'h33, 32'h34, 0);
    tick();
`ifdef OPCOLL_STATS_EN
    @(negedge clk_i);
    check("mid_rst_bundle_cnt", bundle_cnt_o, 1);
    tick();
`endif
    check("directed_drained", exp_q.size(), 0);

    // Randomized: independent opcode, data and ready streams
    for (int n = 0; n < 40; n++) begin
      code_t op;
      data_t b[4];
      op = code_t'($urandom);
      ops.push_back(op);
      for (int k = 0; k < 4; k++) begin
        b[k] = $urandom;
        dq.push_back(b[k]);
      end
      exp_q.push_back(opbundle_t'{op, b[0], b[1], b[2], b[3]});
    end
    fork
      begin
        bit ok;
        foreach (ops[i]) begin
          opcode_valid_i = 1'b0;
          repeat ($urandom_range(0, 3)) tick();
          opcode_i = ops[i];
          opcode_valid_i = 1'b1;
          wait_hs(1'b1, ok);
          if (!ok) check("rand_op_hs", ok, 1);
        end
        opcode_valid_i = 1'b0;
      end
      begin
        bit ok;
        foreach (dq[i]) begin
          rd_data_valid_i = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
          rd_data_i = dq[i];
          rd_data_valid_i = 1'b1;
          wait_hs(1'b0, ok);
          if (!ok) check("rand_data_hs", ok, 1);
        end
        rd_data_valid_i = 1'b0;
      end
      begin
        int guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
          bundle_ready_i = ($urandom_range(0, 2) != 0);
          tick();
          guard++;
        end
        bundle_ready_i = 1'b1;
      end
    join
    repeat (3) tick();
    check("rand_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/operand_collector.md
# operand_collector

Downstream neighbour of the register-file read address sequencer. It receives, in order, the four register-file read-data beats produced for one micro-instruction (vrs1, vrs2, vrs3, vrs3+1) and pairs them with that instruction's opcode from the opcode FIFO. It then presents one complete operand bundle to the execute stage over a valid/ready handshake.

## Interface
- DATA_W, default 32: width of one register-file read beat.
- NUM_BEATS, fixed at 4: beats per bundle. Not a user parameter; documented for readability.
- clk_i  in  1  single clock; all logic on posedge.
- srst_i  in  1  synchronous, active-high reset. Sampled on posedge clk_i only.
- opcode_i  in  code_t  opcode from the opcode FIFO.
- opcode_valid_i  in  1  opcode_i valid.
- opcode_ready_o  out  1  collector accepts opcode_i this cycle.
- rd_data_i  in  DATA_W  register-file read data, one beat.
- rd_data_valid_i  in  1  rd_data_i valid.
- rd_data_ready_o  out  1  collector accepts rd_data_i this cycle.
- bundle_o  out  opbundle_t  {opcode, op_a, op_b, op_c, op_d}.
- bundle_valid_o  out  1  bundle_o complete and stable.
- bundle_ready_i  in  1  execute stage accepts the bundle.

## Operation
- State machine with three states: IDLE, COLLECT, HOLD. Reset state is IDLE.
- IDLE:
  - opcode_ready_o=1, rd_data_ready_o=0.
  - Opcode handshake: latch the opcode, clear beat_cnt to 0, go to COLLECT.
- COLLECT:
  - rd_data_ready_o=1, opcode_ready_o=0.
  - Each data handshake writes rd_data_i into slot beat_cnt (0→op_a, 1→op_b, 2→op_c, 3→op_d), then increments beat_cnt.
  - The handshake on beat 3 moves the block to HOLD.
  - No data handshake: stay in COLLECT and keep all slots.
- HOLD:
  - bundle_valid_o=1, rd_data_ready_o=0.
  - bundle_o stays stable until bundle_ready_i is seen.
  - opcode_ready_o = bundle_ready_i (back-to-back opcode acceptance).
  - bundle_ready_i=1 and opcode_valid_i=1: latch the new opcode, clear beat_cnt, go to COLLECT.
  - bundle_ready_i=1 and opcode_valid_i=0: go to IDLE.
  - bundle_ready_i=0: stay in HOLD.
- beat_cnt is 2 bits. It never wraps inside COLLECT, because the beat-3 handshake always exits the state.
- Data order is fixed. No tag checking; the upstream sequencer guarantees vrs1, vrs2, vrs3, vrs3+1 order.
- Valid signals from upstream are not required to be held. The block samples a beat only on valid&&ready.
- Outputs are driven purely by registered state and the registered bundle. The only combinational path is bundle_ready_i → opcode_ready_o in HOLD.

## Timing
- Reset:
  - srst_i=1 at a posedge forces IDLE, beat_cnt=0 and bundle register=0.
  - Resulting outputs: opcode_ready_o=1 in the following cycle; rd_data_ready_o=0; bundle_valid_o=0; bundle_o=0.
- Reset mid-COLLECT or mid-HOLD: partial or pending bundle is discarded with no output. The upstream is responsible for its own flush.
- Latency, with no stalls:
  - opcode handshake in cycle N.
  - data beats in cycles N+1..N+4.
  - bundle_valid_o=1 from cycle N+5.
- Throughput: one bundle per 5 cycles when bundle_ready_i=1 on the first HOLD cycle and the next opcode is already valid.
- Simultaneous opcode_valid_i and rd_data_valid_i in IDLE: only the opcode is taken. Data is stalled (ready=0).
- bundle_valid_o, once asserted, never deasserts without a bundle handshake, except on reset.

## Configuration
- OPCOLL_STATS_EN:
  - Defined: adds ports bundle_cnt_o (out, 16) and stall_cnt_o (out, 16), both reset to 0 and wrapping modulo 2^16.
    - bundle_cnt_o increments on every bundle handshake.
    - stall_cnt_o increments on every cycle in COLLECT with rd_data_valid_i=0, plus every cycle in HOLD with bundle_ready_i=0.
  - Undefined: the ports and counters do not exist; functional behaviour is identical.

## Structure
- config_pkg gains:
  - data_t (logic [DATA_W-1:0], with DATA_W=32 as a package localparam matching the module default).
  - opbundle_t, a packed struct {code_t opcode; data_t op_a, op_b, op_c, op_d}.
  - the state enum opcoll_state_e {IDLE, COLLECT, HOLD}.
- No sub-module. The FSM, beat counter and bundle register live in one module. Stats counters sit inside the `ifdef region of the same module.

## Test plan
- Reset: hold srst_i=1 for 2 cycles with all inputs valid → bundle_valid_o=0, rd_data_ready_o=0, opcode_ready_o=1 after release, bundle_o=0.
- Single bundle:
  - Stimulus: opcode 0x5, then beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles, bundle_ready_i=1.
  - Response: bundle {0x5, 0x11, 0x22, 0x33, 0x44}, valid exactly 5 cycles after the opcode handshake, for 1 cycle.
- Data gaps: same beats with rd_data_valid_i low for 3 cycles between beats 2 and 3 → same bundle, valid at N+8. With OPCOLL_STATS_EN, stall_cnt_o=3.
- Output backpressure: bundle_ready_i=0 for 4 cycles → bundle_o stable, opcode_ready_o=0, rd_data_ready_o=0. Then bundle_ready_i=1 with the next opcode 0x6 valid → opcode accepted in the same cycle and COLLECT entered.
- Early data: rd_data_valid_i=1 with 0xAA while IDLE and opcode_valid_i=0 → no data accepted. Once opcode 0x7 arrives, 0xAA becomes op_a.
- Reset mid-operation: srst_i after 2 of 4 beats → bundle_valid_o never asserts. A fresh opcode plus 4 beats afterwards produces only the new bundle; bundle_cnt_o=1.
